// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller: register
// addresses, CTRL bit positions, FSM state encoding and blank-display values.
package seg7_scan_ctrl_pkg;

    // Register map of the write port
    localparam logic [1:0] ADDR_HEX  = 2'd0;
    localparam logic [1:0] ADDR_DP   = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    // CTRL bit positions: {raw, lz_blank, enable}
    localparam int CTRL_EN  = 0;
    localparam int CTRL_LZ  = 1;
    localparam int CTRL_RAW = 2;

    // CTRL comes out of reset with the display enabled
    localparam logic [2:0] CTRL_RESET = 3'b001;

    // Everything dark (both buses are active-low)
    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // Active-low anode pattern that lights exactly one digit
    function automatic logic [3:0] an_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register write port of the scan controller.
// Handshake: there is no ready; the slave accepts a write on every rising
// clock edge where wr_en is high, so a master holds wr_en for exactly one
// cycle per register write with wr_addr/wr_data valid in that same cycle.
interface seg7_scan_ctrl_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_hex_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Lookup of the glyph for each hex value
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Digits are lit one at a time for DRIVE_CYCLES, each followed by an all-off
// guard of GUARD_CYCLES. Register writes go to a pending copy and are copied
// to the display copy only when a frame starts, so a frame never mixes old
// and new contents. The enable bit is taken from the pending copy so that a
// disable acts on the very next edge.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned DRIVE_CYCLES = 100000,
    parameter int unsigned GUARD_CYCLES = 1000
) (
    input  logic                    sysclk,
    input  logic                    reset,
    seg7_scan_ctrl_if.slave         wr,
    output logic [3:0]              an,
    output logic [7:0]              bcd7,
    output logic [1:0]              digit_idx,
    output logic                    frame_done,
    output state_t                  dbg_state
);

    localparam logic [31:0] DRIVE_LAST = 32'(DRIVE_CYCLES - 1);
    localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);
    localparam bit          HAS_GUARD  = (GUARD_CYCLES != 0);

    // Pending register copy (written by the bus)
    logic [15:0] pend_hex_q,  pend_hex_d;
    logic [3:0]  pend_dp_q,   pend_dp_d;
    logic [2:0]  pend_ctrl_q, pend_ctrl_d;
    logic [31:0] pend_raw_q,  pend_raw_d;

    // Display register copy (drives the segments)
    logic [15:0] disp_hex;
    logic [3:0]  disp_dp;
    logic [31:0] disp_raw;
    logic        disp_raw_mode;
    logic        disp_lz;

    // FSM
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        commit;
    logic        wrap;
    logic        advance;
    logic        enabled;

    // Output next values
    logic [3:0]  an_d;
    logic [7:0]  bcd7_d;
    logic [1:0]  digit_idx_d;
    logic [6:0]  hex_seg;
    logic        lz_hide;

    assign enabled   = pend_ctrl_q[CTRL_EN];
    assign dbg_state = state_q;

    // Bus write into the pending copy; commit reads this post-write value
    always_comb begin
        pend_hex_d  = pend_hex_q;
        pend_dp_d   = pend_dp_q;
        pend_ctrl_d = pend_ctrl_q;
        pend_raw_d  = pend_raw_q;
        if (wr.wr_en) begin
            case (wr.wr_addr)
                ADDR_HEX:  pend_hex_d  = wr.wr_data[15:0];
                ADDR_DP:   pend_dp_d   = wr.wr_data[3:0];
                ADDR_CTRL: pend_ctrl_d = wr.wr_data[2:0];
                ADDR_RAW:  pend_raw_d  = wr.wr_data;
                default:   pend_raw_d  = pend_raw_q;
            endcase
        end
    end

    // Pending and display register copies
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            pend_hex_q    <= '0;
            pend_dp_q     <= '0;
            pend_ctrl_q   <= CTRL_RESET;
            pend_raw_q    <= '0;
            disp_hex      <= '0;
            disp_dp       <= '0;
            disp_raw      <= '0;
            disp_raw_mode <= CTRL_RESET[CTRL_RAW];
            disp_lz       <= CTRL_RESET[CTRL_LZ];
        end else begin
            pend_hex_q  <= pend_hex_d;
            pend_dp_q   <= pend_dp_d;
            pend_ctrl_q <= pend_ctrl_d;
            pend_raw_q  <= pend_raw_d;
            if (commit) begin
                disp_hex      <= pend_hex_d;
                disp_dp       <= pend_dp_d;
                disp_raw      <= pend_raw_d;
                disp_raw_mode <= pend_ctrl_d[CTRL_RAW];
                disp_lz       <= pend_ctrl_d[CTRL_LZ];
            end
        end
    end

    // FSM state, digit index and slot counter
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: disable wins over everything, otherwise scan the digits
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        wrap    = 1'b0;
        advance = 1'b0;
        if (!enabled) begin
            state_d = ST_OFF;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    commit  = 1'b1;
                    state_d = ST_DRIVE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        cnt_d = '0;
                        if (HAS_GUARD) state_d = ST_GUARD;
                        else           advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d   = '0;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
            if (advance) begin
                state_d = ST_DRIVE;
                if (idx_q == 2'd3) begin
                    idx_d  = 2'd0;
                    wrap   = 1'b1;
                    commit = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
        end
    end

    seg7_hex_decoder u_hex (
        .nibble (disp_hex[{idx_q, 2'b00} +: 4]),
        .seg    (hex_seg)
    );

    // Segment/anode selection for the current state and digit
    always_comb begin
        an_d        = AN_OFF;
        bcd7_d      = SEG_OFF;
        digit_idx_d = enabled ? idx_q : 2'd0;
        lz_hide     = disp_lz && (idx_q != 2'd0) &&
                      ((disp_hex >> {idx_q, 2'b00}) == 16'h0000);
        if (enabled && state_q == ST_DRIVE) begin
            if (disp_raw_mode) begin
                an_d   = an_for(idx_q);
                bcd7_d = disp_raw[{idx_q, 3'b000} +: 8];
            end else if (!lz_hide) begin
                an_d   = an_for(idx_q);
                bcd7_d = {~disp_dp[idx_q], hex_seg};
            end
        end
    end

    // Registered outputs
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            an         <= AN_OFF;
            bcd7       <= SEG_OFF;
            digit_idx  <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            bcd7       <= bcd7_d;
            digit_idx  <= digit_idx_d;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with DRIVE_CYCLES=4, GUARD_CYCLES=1 (20-cycle frame).
module tb_seg7_scan_ctrl;
    import seg7_scan_ctrl_pkg::*;

    logic       sysclk;
    logic       reset;
    logic [3:0] an;
    logic [7:0] bcd7;
    logic [1:0] digit_idx;
    logic       frame_done;
    state_t     dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(
        .DRIVE_CYCLES (4),
        .GUARD_CYCLES (1)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .wr         (bus),
        .an         (an),
        .bcd7       (bcd7),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [2:0]  ctrl;
        logic [31:0] raw;
        logic [15:0] exp_an;   // nibble k = anodes while digit k is scanned
        logic [31:0] exp_seg;  // byte k   = bcd7 while digit k is scanned
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One register write; call on a falling edge, returns one cycle later
    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge sysclk);
        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 32'd0;
    endtask

    // Return on the falling edge where frame_done is seen high
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_frame_timeout: got no frame_done expected pulse within 40 cycles", tag);
        end
    endtask

    // Called right after wait_frame: sample the middle of each digit's lit slot
    task automatic check_frame(input string tag, input logic [15:0] ea, input logic [31:0] es);
        int cur;
        cur = 0;
        for (int k = 0; k < 4; k++) begin
            repeat (3 + 5 * k - cur) @(negedge sysclk);
            cur = 3 + 5 * k;
            check($sformatf("%s_d%0d_an", tag, k), 32'(an), 32'(ea[4*k +: 4]));
            check($sformatf("%s_d%0d_seg", tag, k), 32'(bcd7), 32'(es[8*k +: 8]));
            check($sformatf("%s_d%0d_idx", tag, k), 32'(digit_idx), k);
        end
    endtask

    initial begin
        int cycles;

        vecs[0]  = '{hex:16'h0000, dp:4'h0, ctrl:3'b001, raw:32'h0,        exp_an:16'h7BDE, exp_seg:32'hC0C0C0C0};
        vecs[1]  = '{hex:16'h12AF, dp:4'h0, ctrl:3'b001, raw:32'h0,        exp_an:16'h7BDE, exp_seg:32'hF9A4888E};
        vecs[2]  = '{hex:16'h0007, dp:4'h0, ctrl:3'b011, raw:32'h0,        exp_an:16'hFFFE, exp_seg:32'hFFFFFFF8};
        vecs[3]  = '{hex:16'h0007, dp:4'h1, ctrl:3'b011, raw:32'h0,        exp_an:16'hFFFE, exp_seg:32'hFFFFFF78};
        vecs[4]  = '{hex:16'h0A05, dp:4'h6, ctrl:3'b011, raw:32'h0,        exp_an:16'hFBDE, exp_seg:32'hFF084092};
        vecs[5]  = '{hex:16'h0A05, dp:4'hF, ctrl:3'b101, raw:32'h3F7F00FF, exp_an:16'h7BDE, exp_seg:32'h3F7F00FF};
        vecs[6]  = '{hex:16'hC9D3, dp:4'h0, ctrl:3'b001, raw:32'h0,        exp_an:16'h7BDE, exp_seg:32'hC690A1B0};
        vecs[7]  = '{hex:16'h0000, dp:4'h0, ctrl:3'b111, raw:32'h0,        exp_an:16'h7BDE, exp_seg:32'h00000000};
        vecs[8]  = '{hex:16'h8888, dp:4'h8, ctrl:3'b001, raw:32'h0,        exp_an:16'h7BDE, exp_seg:32'h00808080};
        vecs[9]  = '{hex:16'h4567, dp:4'h0, ctrl:3'b011, raw:32'h0,        exp_an:16'h7BDE, exp_seg:32'h999282F8};
        vecs[10] = '{hex:16'hBE00, dp:4'h0, ctrl:3'b011, raw:32'h0,        exp_an:16'h7BDE, exp_seg:32'h8386C0C0};
        vecs[11] = '{hex:16'h0010, dp:4'h0, ctrl:3'b011, raw:32'h0,        exp_an:16'hFFDE, exp_seg:32'hFFFFF9C0};

        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 32'd0;
        reset       = 1'b1;

        // Reset values and first digit after release
        repeat (3) @(negedge sysclk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(bcd7), 32'hFF);
        check("rst_idx", 32'(digit_idx), 0);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_OFF));
        reset = 1'b0;
        @(negedge sysclk);
        check("start_an_blank", 32'(an), 32'hF);
        @(negedge sysclk);
        check("start_an", 32'(an), 32'hE);
        check("start_seg", 32'(bcd7), 32'hC0);
        repeat (4) @(negedge sysclk);
        check("guard_an", 32'(an), 32'hF);
        check("guard_seg", 32'(bcd7), 32'hFF);

        // Frame period and pulse width
        wait_frame("period");
        @(negedge sysclk);
        check("fd_width", 32'(frame_done), 0);
        cycles = 1;
        while (frame_done !== 1'b1 && cycles < 40) begin
            @(negedge sysclk);
            cycles++;
        end
        check("fd_period", cycles, 20);

        // Mid-frame write leaves the current frame untouched
        repeat (7) @(negedge sysclk);
        check("mid_d1_seg", 32'(bcd7), 32'hC0);
        write_reg(ADDR_HEX, 32'hFFFF_12AF);
        repeat (5) @(negedge sysclk);
        check("mid_d2_an", 32'(an), 32'hB);
        check("mid_d2_seg", 32'(bcd7), 32'hC0);
        repeat (5) @(negedge sysclk);
        check("mid_d3_seg", 32'(bcd7), 32'hC0);
        wait_frame("mid");
        check_frame("mid_next", 16'h7BDE, 32'hF9A4888E);

        // Table of register settings and the frame they produce
        for (int v = 0; v < NVEC; v++) begin
            write_reg(ADDR_HEX, {16'hA5A5, vecs[v].hex});
            write_reg(ADDR_DP, {28'hFFFFFF0, vecs[v].dp});
            write_reg(ADDR_RAW, vecs[v].raw);
            write_reg(ADDR_CTRL, {29'h0, vecs[v].ctrl});
            wait_frame($sformatf("vec%0d", v));
            check_frame($sformatf("vec%0d", v), vecs[v].exp_an, vecs[v].exp_seg);
        end

        // Disable in the middle of digit 2, then re-enable
        write_reg(ADDR_HEX, 32'h0);
        write_reg(ADDR_CTRL, 32'h1);
        wait_frame("dis");
        repeat (12) @(negedge sysclk);
        check("dis_pre_an", 32'(an), 32'hB);
        write_reg(ADDR_CTRL, 32'h0);
        @(negedge sysclk);
        check("dis_an", 32'(an), 32'hF);
        check("dis_seg", 32'(bcd7), 32'hFF);
        check("dis_idx", 32'(digit_idx), 0);
        check("dis_state", 32'(dbg_state), 32'(ST_OFF));
        write_reg(ADDR_CTRL, 32'h1);
        repeat (2) @(negedge sysclk);
        check("reen_an", 32'(an), 32'hE);
        check("reen_seg", 32'(bcd7), 32'hC0);
        check("reen_idx", 32'(digit_idx), 0);

        // Asynchronous reset while digit 1 is lit
        write_reg(ADDR_HEX, 32'h12AF);
        wait_frame("arst_setup");
        wait_frame("arst");
        repeat (8) @(negedge sysclk);
        check("arst_pre_an", 32'(an), 32'hD);
        check("arst_pre_seg", 32'(bcd7), 32'h88);
        #2;
        reset = 1'b1;
        #1;
        check("arst_an", 32'(an), 32'hF);
        check("arst_seg", 32'(bcd7), 32'hFF);
        check("arst_idx", 32'(digit_idx), 0);
        @(negedge sysclk);
        reset = 1'b0;
        wait_frame("arst_post");
        check_frame("arst_post", 16'h7BDE, 32'hC0C0C0C0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000ns");
        $fatal(1);
    end

endmodule
